// File: rtl/iterative_compare_unit.sv
`default_nettype none
// ============================================================================
// Module      : iterative_compare_unit
// Description : Multi-cycle branch/set condition evaluator. Compares two
//               WIDTH-bit operands SLICE bits per cycle, MSB slice first,
//               and stops at the first differing slice. A start/busy/done
//               handshake lets the control unit stall until resolved.
// Ports       : clk, rst (async, active-high)
//               start, a, b, op     - request and operands (sampled on accept)
//               busy                - high whenever not idle
//               done                - one-cycle pulse, outputs valid from it
//               result              - condition outcome for the latched op
//               eq_flag/ltu_flag/lts_flag - equality / unsigned / signed less
// Revision    : 1.0 - initial release
// ============================================================================
module iterative_compare_unit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic             result,
    output logic             eq_flag,
    output logic             ltu_flag,
    output logic             lts_flag
);

    localparam int c_NSLICES = WIDTH / SLICE;
    localparam int c_IDX_W   = (c_NSLICES > 1) ? $clog2(c_NSLICES) : 1;
    localparam logic [c_IDX_W-1:0] c_TOP = c_IDX_W'(c_NSLICES - 1);

    // Condition codes
    localparam logic [2:0] c_OP_GES = 3'b001;
    localparam logic [2:0] c_OP_LTS = 3'b010;
    localparam logic [2:0] c_OP_NE  = 3'b011;
    localparam logic [2:0] c_OP_EQ  = 3'b100;
    localparam logic [2:0] c_OP_GEU = 3'b101;
    localparam logic [2:0] c_OP_LTU = 3'b110;
    localparam logic [2:0] c_OP_GTU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CMP  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             r_state;
    logic [c_IDX_W-1:0] r_idx;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_op;
    logic               r_busy;
    logic               r_done;
    logic               r_result;
    logic               r_eq;
    logic               r_ltu;
    logic               r_lts;

    logic [SLICE-1:0]   w_sa;
    logic [SLICE-1:0]   w_sb;
    logic [SLICE-1:0]   w_sa_s;
    logic [SLICE-1:0]   w_sb_s;
    logic               w_top;
    logic               w_diff;
    logic               w_slice_ltu;
    logic               w_slice_lts;
    logic               w_fin_eq;
    logic               w_fin_ltu;
    logic               w_fin_lts;
    logic               w_fin_result;

    // Slice under examination plus the flag values that would be committed
    // if the comparison resolves in this cycle.
    always_comb begin
        w_sa   = r_a[int'(r_idx) * SLICE +: SLICE];
        w_sb   = r_b[int'(r_idx) * SLICE +: SLICE];
        w_top  = (r_idx == c_TOP);
        w_sa_s = w_sa;
        w_sb_s = w_sb;
        // Flipping the sign bit on the MSB slice turns a two's-complement
        // order into an unsigned one; lower slices order identically.
        if (w_top) begin
            w_sa_s[SLICE-1] = ~w_sa[SLICE-1];
            w_sb_s[SLICE-1] = ~w_sb[SLICE-1];
        end
        w_diff      = (w_sa != w_sb);
        w_slice_ltu = (w_sa < w_sb);
        w_slice_lts = w_top ? (w_sa_s < w_sb_s) : w_slice_ltu;

        w_fin_eq  = ~w_diff;
        w_fin_ltu = w_diff & w_slice_ltu;
        w_fin_lts = w_diff & w_slice_lts;

        w_fin_result = 1'b0;
        case (r_op)
            c_OP_EQ:  w_fin_result = w_fin_eq;
            c_OP_NE:  w_fin_result = ~w_fin_eq;
            c_OP_GEU: w_fin_result = ~w_fin_ltu;
            c_OP_LTU: w_fin_result = w_fin_ltu;
            c_OP_GES: w_fin_result = ~w_fin_lts;
            c_OP_LTS: w_fin_result = w_fin_lts;
            c_OP_GTU: w_fin_result = ~w_fin_ltu & ~w_fin_eq;
            default:  w_fin_result = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 1'b0;
            r_eq     <= 1'b0;
            r_ltu    <= 1'b0;
            r_lts    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op;
                        r_idx   <= c_TOP;
                        r_busy  <= 1'b1;
                        r_state <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (w_diff || (r_idx == '0)) begin
                        r_eq     <= w_fin_eq;
                        r_ltu    <= w_fin_ltu;
                        r_lts    <= w_fin_lts;
                        r_result <= w_fin_result;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_idx <= r_idx - c_IDX_W'(1);
                    end
                end
                S_DONE: begin
                    // Always pass through IDLE so start is never taken here.
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign eq_flag  = r_eq;
    assign ltu_flag = r_ltu;
    assign lts_flag = r_lts;

endmodule
`default_nettype wire

// File: tb/tb_iterative_compare_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_iterative_compare_unit
// Description : Self-checking bench for iterative_compare_unit (32/8).
//               Expected values come from a plain-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iterative_compare_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        busy;
    logic        done;
    logic        result;
    logic        eq_flag;
    logic        ltu_flag;
    logic        lts_flag;

    int n_cmp;
    int n_fail;

    iterative_compare_unit #(.WIDTH(32), .SLICE(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .op       (op),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .eq_flag  (eq_flag),
        .ltu_flag (ltu_flag),
        .lts_flag (lts_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Number of slices looked at before resolution: MSB-first, stop at first difference.
    function automatic int ref_slices(input logic [31:0] x, input logic [31:0] y);
        for (int s = 3; s >= 0; s--)
            if (x[s*8 +: 8] != y[s*8 +: 8]) return 4 - s;
        return 4;
    endfunction

    function automatic logic ref_result(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
        logic e, lu, ls;
        e  = (x == y);
        lu = (x < y);
        ls = ($signed(x) < $signed(y));
        case (c)
            3'b100:  return e;
            3'b011:  return !e;
            3'b101:  return !lu;
            3'b110:  return lu;
            3'b001:  return !ls;
            3'b010:  return ls;
            3'b111:  return !lu && !e;
            default: return 1'b0;
        endcase
    endfunction

    // One full transaction; with hammer set, start stays high and operands
    // churn for the whole busy period.
    task automatic run(input string tag, input logic [31:0] xa, input logic [31:0] xb,
                       input logic [2:0] xop, input bit hammer);
        int edges;
        bit got;
        @(negedge clk);
        a = xa; b = xb; op = xop; start = 1'b1;
        @(posedge clk); #1;
        check({tag, " busy"}, 32'(busy), 32'd1);
        edges = 1;
        got   = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            start = hammer;
            a = $urandom; b = $urandom; op = 3'($urandom_range(0, 7));
            @(posedge clk); #1;
            edges++;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        check({tag, " done seen"}, 32'(got), 32'd1);
        check({tag, " latency"}, 32'(edges), 32'(ref_slices(xa, xb) + 1));
        check({tag, " result"}, 32'(result), 32'(ref_result(xop, xa, xb)));
        check({tag, " flags"}, {29'd0, eq_flag, ltu_flag, lts_flag},
              {29'd0, xa == xb, xa < xb, $signed(xa) < $signed(xb)});
        @(posedge clk); #1;
        check({tag, " pulse one cycle"}, {30'd0, done, busy}, 32'd0);
        @(posedge clk); #1;
        check({tag, " no restart"}, {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb, mask;
        int k;
        bit seen;
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; op = '0;
        @(posedge clk); #1;
        check("reset outputs", {26'd0, busy, done, result, eq_flag, ltu_flag, lts_flag}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run("EQ equal",   32'h12345678, 32'h12345678, 3'b100, 1'b0);
        run("GES",        32'h00000001, 32'hFFFFFFFF, 3'b001, 1'b0);
        run("LTU",        32'h00000001, 32'hFFFFFFFF, 3'b110, 1'b0);
        run("GEU",        32'h00000001, 32'hFFFFFFFF, 3'b101, 1'b0);
        run("LTS",        32'h80000000, 32'h00000000, 3'b010, 1'b0);
        run("GTU",        32'h80000000, 32'h00000000, 3'b111, 1'b0);
        run("NE equal",   32'hDEADBEEF, 32'hDEADBEEF, 3'b011, 1'b0);
        run("op000",      32'h00000005, 32'h00000003, 3'b000, 1'b0);
        run("LTS low",    32'hFFFFFF00, 32'hFFFFFF7F, 3'b010, 1'b0);
        run("late LTU",   32'hAABBCC01, 32'hAABBCC02, 3'b110, 1'b1);

        // Async reset during the second CMP cycle; result is 1 from above.
        @(negedge clk);
        a = 32'h0; b = 32'h0; op = 3'b100; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1; #1;
        check("abort outputs", {29'd0, busy, done, result}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        check("abort no pulse", 32'(seen), 32'd0);
        run("after abort", 32'h0, 32'h0, 3'b100, 1'b0);

        // Randomised: differences confined to a random number of low slices.
        for (int t = 0; t < 24; t++) begin
            ra   = $urandom;
            k    = int'($urandom_range(0, 4));
            mask = (k == 4) ? 32'h0 : (32'hFFFFFFFF >> (8 * k));
            rb   = ra ^ ($urandom & mask);
            run($sformatf("rand%0d", t), ra, rb, 3'($urandom_range(0, 7)), t[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iterative_compare_unit.md
Name: iterative_compare_unit

Overview:
- Parametrised, multi-cycle successor to the single-cycle branch comparison unit. It sits beside the ALU in the execute stage and evaluates branch/set conditions on WIDTH-bit operands.
- Operands are compared SLICE bits per cycle, starting from the MSB slice. Evaluation stops early at the first differing slice.
- A start/busy/done handshake lets the control unit stall until the condition is resolved.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of SLICE.
- SLICE, 8, bits compared per cycle; NSLICES = WIDTH/SLICE, must be at least 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a comparison; accepted only while busy=0.
- a  input  WIDTH  operand A; sampled on the accept edge.
- b  input  WIDTH  operand B; sampled on the accept edge.
- op  input  3  condition code; sampled on the accept edge.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse; result and flags are valid from this cycle.
- result  output  1  condition outcome for the latched op.
- eq_flag  output  1  a == b.
- ltu_flag  output  1  a < b, unsigned.
- lts_flag  output  1  a < b, signed two's complement.

Behaviour:
- Reset (async, any state): state=IDLE, slice index=0, busy=0, done=0, result=0, all flags=0, and the operand/op registers are cleared.
- States are IDLE, CMP and DONE.
- IDLE:
  - If start=1 at a rising edge, latch a, b and op, set index=NSLICES-1, and go to CMP.
  - Otherwise stay in IDLE.
- CMP: each cycle compares slice [index*SLICE +: SLICE] of the latched operands.
  - Slices differ: set eq=0, ltu=(slice_a < slice_b) unsigned, and go to DONE.
  - For the signed flag, the MSB slice is compared with bit WIDTH-1 inverted on both operands. lts takes this result if the MSB slice differs. Otherwise lts equals ltu from the first differing lower slice.
  - Slices equal and index=0: set eq=1, ltu=0, lts=0, and go to DONE.
  - Slices equal and index>0: decrement index and stay in CMP.
- DONE: done=1 for exactly this cycle, then unconditionally go to IDLE.
- result, eq_flag, ltu_flag and lts_flag are registered when DONE is entered. They hold until the next DONE or reset.
- Latency: with k slices examined (1 to NSLICES), done is high in the cycle after the (k+1)-th rising edge counted from the accept edge.
  - Minimum latency is 2 edges; maximum is NSLICES+1 edges.
  - A new start can be accepted on the edge that leaves DONE? No: DONE always returns to IDLE first. start is accepted at the earliest on the edge after DONE, so the issue rate is one comparison per k+2 cycles.
- start while busy=1 (CMP or DONE) is ignored. Operand and op changes while busy have no effect.
- op decode (result):
  - 100 EQ = eq
  - 011 NE = ~eq
  - 101 GEU = ~ltu
  - 110 LTU = ltu
  - 001 GES = ~lts
  - 010 LTS = lts
  - 111 GTU = ~ltu & ~eq
  - 000 = 0
- NSLICES=1 is legal: one CMP cycle, then DONE.
- Reset asserted mid-CMP or in DONE aborts the comparison. No done pulse is produced for the aborted request.

Test Plan (WIDTH=32, SLICE=8):
- EQ, a=b=0x12345678, op=100 -> 4 CMP cycles; done in the cycle after the 5th edge; result=1, eq=1, ltu=0, lts=0.
- GES, a=0x00000001, b=0xFFFFFFFF, op=001 -> exits after 1 slice (done after the 2nd edge); result=1, lts=0, ltu=1, eq=0.
- LTU, same operands, op=110 -> result=1. Repeat with op=101 (GEU) -> result=0.
- LTS, a=0x80000000, b=0x00000000, op=010 -> result=1. Repeat with op=111 (GTU) -> result=1.
- Late-slice difference, a=0xAABBCC01, b=0xAABBCC02, op=110 -> 4 CMP cycles; result=1. Pulse start again while busy -> ignored; exactly one done pulse.
- Reset mid-operation: start EQ on 0x0/0x0, assert rst during the 2nd CMP cycle -> busy, done and result are 0 immediately (asynchronous); no done pulse follows. A new start after rst deasserts completes normally.
